// File: rtl/bus_dispatcher_pkg.sv
// bus_dispatcher_pkg: shared widths, error codes and FSM states for the bus dispatcher
package bus_dispatcher_pkg;
  localparam int WORDSIZE      = 16;
  localparam int COMMAND_WIDTH = 4;
  localparam int ERROR_WIDTH   = 4;
  typedef logic [COMMAND_WIDTH-1:0] unit_id_t;
  typedef enum logic [ERROR_WIDTH-1:0] {
    ERROR_NONE            = 4'h0,
    ERROR_TIMEOUT         = 4'h1,
    ERROR_NO_ACK_RESERVED = 4'h2,
    ERROR_INVALID_INPUT   = 4'hF
  } error_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} dispatch_state_t;
endpackage

// File: rtl/bus_dispatcher_if.sv
// bus_dispatcher_if: request, unit-fanout and response handshakes of the dispatcher
interface bus_dispatcher_if import bus_dispatcher_pkg::*; #(
  parameter int WORDSIZE      = bus_dispatcher_pkg::WORDSIZE,
  parameter int COMMAND_WIDTH = bus_dispatcher_pkg::COMMAND_WIDTH,
  parameter int ERROR_WIDTH   = bus_dispatcher_pkg::ERROR_WIDTH,
  parameter int NUM_UNITS     = 4
);
  logic                             req_valid;
  logic                             req_ready;
  logic [COMMAND_WIDTH-1:0]         req_unit;
  logic [COMMAND_WIDTH-1:0]         req_cmd;
  logic [WORDSIZE-1:0]              req_data;
  logic [NUM_UNITS-1:0]             unit_valid;
  logic [COMMAND_WIDTH-1:0]         unit_cmd;
  logic [WORDSIZE-1:0]              unit_data;
  logic [NUM_UNITS-1:0]             unit_ack;
  logic [NUM_UNITS*WORDSIZE-1:0]    unit_rdata;
  logic [NUM_UNITS*ERROR_WIDTH-1:0] unit_error;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [WORDSIZE-1:0]              rsp_data;
  logic [ERROR_WIDTH-1:0]           rsp_error;
  modport master (
    output req_valid, req_unit, req_cmd, req_data, unit_ack, unit_rdata, unit_error, rsp_ready,
    input  req_ready, unit_valid, unit_cmd, unit_data, rsp_valid, rsp_data, rsp_error
  );
  modport slave (
    input  req_valid, req_unit, req_cmd, req_data, unit_ack, unit_rdata, unit_error, rsp_ready,
    output req_ready, unit_valid, unit_cmd, unit_data, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/bus_dispatcher_timer.sv
// bus_timeout_timer: counts enabled cycles from zero and flags the last allowed one
module bus_timeout_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;
  logic [W-1:0] count;
  assign expired = en && count == W'(LIMIT - 1);
  // clear has priority so every ISSUE phase starts counting from zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (en && !expired) count <= count + 1'b1;
endmodule

// File: rtl/bus_dispatcher.sv
// bus_dispatcher: routes one request to a unit, waits for its ack or a timeout, returns the response
// Optional statistics counters are built when BUS_DISPATCH_STATS_EN is defined.
module bus_dispatcher import bus_dispatcher_pkg::*; #(
  parameter int WORDSIZE       = bus_dispatcher_pkg::WORDSIZE,
  parameter int COMMAND_WIDTH  = bus_dispatcher_pkg::COMMAND_WIDTH,
  parameter int ERROR_WIDTH    = bus_dispatcher_pkg::ERROR_WIDTH,
  parameter int NUM_UNITS      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  bus_dispatcher_if.slave bus,
  output logic        busy,
  output logic [15:0] stat_txn_count,
  output logic [15:0] stat_err_count
);
  localparam int IDX_W = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  dispatch_state_t state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] req_idx;
  logic id_ok;
  logic expired;
  assign id_ok   = bus.req_unit != '0 && bus.req_unit <= COMMAND_WIDTH'(NUM_UNITS);
  assign req_idx = IDX_W'(bus.req_unit - 1'b1);
  bus_timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != ISSUE),
    .en      (state == ISSUE),
    .expired (expired)
  );
  // dispatch FSM; every bus output is a register so units and consumer see glitch-free strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.unit_valid <= '0;
      bus.unit_cmd   <= '0;
      bus.unit_data  <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_error  <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.req_valid) begin
            bus.unit_cmd  <= bus.req_cmd;
            bus.unit_data <= bus.req_data;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (id_ok) begin
              idx            <= req_idx;
              bus.unit_valid <= NUM_UNITS'(1) << req_idx;
              state          <= ISSUE;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= '0;
              bus.rsp_error <= '1;
              state         <= RESP;
            end
          end
        ISSUE:
          if (bus.unit_ack[idx] || expired) begin
            bus.unit_valid <= '0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_data   <= bus.unit_ack[idx] ? bus.unit_rdata[idx*WORDSIZE +: WORDSIZE] : '0;
            bus.rsp_error  <= bus.unit_ack[idx] ? bus.unit_error[idx*ERROR_WIDTH +: ERROR_WIDTH]
                                                : ERROR_WIDTH'(ERROR_TIMEOUT);
            state          <= RESP;
          end
        default:
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
      endcase
    end
`ifdef BUS_DISPATCH_STATS_EN
  // saturating counts of response handshakes, total and with a non-zero error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_txn_count <= '0;
      stat_err_count <= '0;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      if (stat_txn_count != 16'hFFFF) stat_txn_count <= stat_txn_count + 1'b1;
      if (bus.rsp_error != '0 && stat_err_count != 16'hFFFF) stat_err_count <= stat_err_count + 1'b1;
    end
`else
  assign stat_txn_count = '0;
  assign stat_err_count = '0;
`endif
endmodule

// File: tb/tb_bus_dispatcher.sv
// tb_bus_dispatcher: directed checks of dispatch, bad IDs, timeout, backpressure, async reset and stats
module tb_bus_dispatcher;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  logic [15:0] txn, errc;
  int n_tests = 0;
  int n_fail = 0;
  int n;
  bus_dispatcher_if bus ();
  bus_dispatcher dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .busy           (busy),
    .stat_txn_count (txn),
    .stat_err_count (errc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] u, input logic [3:0] c, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_unit  = u;
    bus.req_cmd   = c;
    bus.req_data  = d;
    tick();
    bus.req_valid = 1'b0;
  endtask
  task automatic set_unit(input int u, input logic [15:0] d, input logic [3:0] e);
    bus.unit_rdata[u*16 +: 16] = d;
    bus.unit_error[u*4 +: 4]   = e;
  endtask
  task automatic take_rsp;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask
  initial begin
    bus.req_valid  = 1'b0;
    bus.req_unit   = '0;
    bus.req_cmd    = '0;
    bus.req_data   = '0;
    bus.unit_ack   = '0;
    bus.unit_rdata = '0;
    bus.unit_error = '0;
    bus.rsp_ready  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_unit_valid", bus.unit_valid, 4'b0000);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_txn", txn, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    send(4'd1, 4'h3, 16'h1234);
    chk("basic_valid1", bus.unit_valid, 4'b0001);
    chk("basic_cmd", bus.unit_cmd, 4'h3);
    chk("basic_data", bus.unit_data, 16'h1234);
    chk("basic_req_ready", bus.req_ready, 1'b0);
    chk("basic_busy", busy, 1'b1);
    tick();
    chk("basic_valid2", bus.unit_valid, 4'b0001);
    set_unit(0, 16'hBEEF, 4'h0);
    bus.unit_ack = 4'b0001;
    tick();
    bus.unit_ack = '0;
    chk("basic_rsp_valid", bus.rsp_valid, 1'b1);
    chk("basic_rsp_data", bus.rsp_data, 16'hBEEF);
    chk("basic_rsp_error", bus.rsp_error, 4'h0);
    chk("basic_valid_drop", bus.unit_valid, 4'b0000);
    take_rsp();
    chk("basic_idle_rsp", bus.rsp_valid, 1'b0);
    chk("basic_idle_ready", bus.req_ready, 1'b1);
    set_unit(0, 16'h1111, 4'h0);
    send(4'd0, 4'h1, 16'hAAAA);
    chk("inv0_unit_valid", bus.unit_valid, 4'b0000);
    chk("inv0_rsp_valid", bus.rsp_valid, 1'b1);
    chk("inv0_rsp_error", bus.rsp_error, 4'hF);
    chk("inv0_rsp_data", bus.rsp_data, 16'h0000);
    take_rsp();
    send(4'd5, 4'h2, 16'h5555);
    chk("inv5_unit_valid", bus.unit_valid, 4'b0000);
    chk("inv5_rsp_valid", bus.rsp_valid, 1'b1);
    chk("inv5_rsp_error", bus.rsp_error, 4'hF);
    chk("inv5_rsp_data", bus.rsp_data, 16'h0000);
    take_rsp();
    set_unit(2, 16'hAAAA, 4'h7);
    send(4'd3, 4'h4, 16'h0042);
    n = 0;
    while (bus.unit_valid === 4'b0100 && n < 40) begin
      n++;
      tick();
    end
    chk("to_valid_cycles", n, 16);
    chk("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk("to_rsp_error", bus.rsp_error, 4'h1);
    chk("to_rsp_data", bus.rsp_data, 16'h0000);
    take_rsp();
    set_unit(2, 16'h5A5A, 4'h0);
    send(4'd3, 4'h4, 16'h0043);
    for (int i = 0; i < 15; i++) tick();
    chk("to16_still_valid", bus.unit_valid, 4'b0100);
    bus.unit_ack = 4'b0100;
    tick();
    bus.unit_ack = '0;
    chk("to16_rsp_valid", bus.rsp_valid, 1'b1);
    chk("to16_rsp_data", bus.rsp_data, 16'h5A5A);
    chk("to16_rsp_error", bus.rsp_error, 4'h0);
    take_rsp();
    set_unit(3, 16'h7777, 4'h0);
    send(4'd4, 4'h5, 16'h0099);
    bus.unit_ack = 4'b0111;
    tick();
    tick();
    chk("stray_issue_valid", bus.unit_valid, 4'b1000);
    chk("stray_issue_rsp", bus.rsp_valid, 1'b0);
    bus.unit_ack = 4'b1000;
    tick();
    set_unit(3, 16'hDEAD, 4'h9);
    bus.unit_ack = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_data", bus.rsp_data, 16'h7777);
      chk("bp_rsp_error", bus.rsp_error, 4'h0);
      chk("bp_req_ready", bus.req_ready, 1'b0);
      chk("bp_unit_valid", bus.unit_valid, 4'b0000);
      tick();
    end
    bus.unit_ack = '0;
    take_rsp();
    chk("bp_idle_ready", bus.req_ready, 1'b1);
`ifdef BUS_DISPATCH_STATS_EN
    chk("stat_txn", txn, 16'd6);
    chk("stat_err", errc, 16'd3);
`else
    chk("stat_txn_off", txn, 16'd0);
    chk("stat_err_off", errc, 16'd0);
`endif
    send(4'd2, 4'h6, 16'h0077);
    chk("mid_valid", bus.unit_valid, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.unit_valid, 4'b0000);
    chk("mid_rst_ready", bus.req_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rsp", bus.rsp_valid, 1'b0);
    chk("mid_rst_cmd", bus.unit_cmd, 4'h0);
    chk("mid_rst_txn", txn, 16'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_rsp", bus.rsp_valid, 1'b0);
    set_unit(1, 16'h2222, 4'h0);
    send(4'd2, 4'h7, 16'h0088);
    chk("post_valid", bus.unit_valid, 4'b0010);
    bus.unit_ack = 4'b0010;
    tick();
    bus.unit_ack = '0;
    chk("post_rsp_data", bus.rsp_data, 16'h2222);
    chk("post_rsp_error", bus.rsp_error, 4'h0);
    take_rsp();
`ifdef BUS_DISPATCH_STATS_EN
    chk("post_stat_txn", txn, 16'd1);
    chk("post_stat_err", errc, 16'd0);
`else
    chk("post_stat_txn_off", txn, 16'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
